// File: rtl/cfg_deser_pkg.sv
// -----------------------------------------------------------------------------
// cfg_deser_pkg
// Shared constants and helpers for the configuration-stream byte deserialiser.
//   BYTE_W              - width of an assembled byte
//   DEFAULT_TOTAL_BYTES - default byte count before dat_done asserts
//   clog2()             - ceil(log2(value)), used for FIFO pointer widths
// -----------------------------------------------------------------------------
package cfg_deser_pkg;

  localparam int BYTE_W = 8;

  localparam int unsigned DEFAULT_TOTAL_BYTES = 32'd19878974;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cfg_byte_fifo.sv
// -----------------------------------------------------------------------------
// cfg_byte_fifo
// Synchronous first-word fall-through byte FIFO.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset (empties the FIFO)
//   push_i   - write din_i; accepted when not full, or when full and a pop
//              happens in the same cycle
//   din_i    - byte to write
//   pop_i    - remove the head entry; ignored while empty
//   dout_o   - head entry (meaningful only while empty_o is low)
//   empty_o  - no entries
//   full_o   - DEPTH entries
// Parameter DEPTH must be a power of two (4..256).
// -----------------------------------------------------------------------------
module cfg_byte_fifo
  import cfg_deser_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  // One bit wider than the pointers so full and empty never alias.
  logic [AW:0]   count_q, count_d;

  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // Fall-through read: the head entry is visible without a read request.
  assign dout_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cfg_byte_deser.sv
// -----------------------------------------------------------------------------
// cfg_byte_deser
// Assembles the loader's serial configuration stream (cfg_clk_i/cfg_dat_i,
// generated in the clk_i domain) MSB-first into bytes, buffers them in a
// FWFT FIFO and raises dat_done_o once TOTAL_BYTES bytes have arrived.
// Ports:
//   clk_i         - 50 MHz system clock
//   reset_i       - synchronous active-high reset
//   cfg_clk_i     - serial bit clock; data sampled on its rising edge
//   cfg_dat_i     - serial data
//   en_i          - capture enable; rises seen while low are ignored
//   byte_o        - head-of-FIFO byte (0 while byte_valid_o is low)
//   byte_valid_o  - FIFO not empty
//   byte_ready_i  - consumer takes byte_o when valid & ready
//   byte_cnt_o    - completed bytes since reset, saturating
//   dat_done_o    - sticky, byte count reached TOTAL_BYTES
//   overflow_o    - sticky, a completed byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module cfg_byte_deser
  import cfg_deser_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter int unsigned TOTAL_BYTES = DEFAULT_TOTAL_BYTES,
  parameter int          CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_clk_i,
  input  logic              cfg_dat_i,
  input  logic              en_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic              dat_done_o,
  output logic              overflow_o
);

  // Previous cfg_clk level. Resets high so a line that is already high
  // when reset releases is not mistaken for a rising edge.
  logic              cfg_clk_prev_q;
  // Only the 7 earlier bits need storing; the 8th comes straight from
  // cfg_dat_i in the completing cycle.
  logic [BYTE_W-2:0] shreg_q, shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              dat_done_q, dat_done_d;
  logic              overflow_q, overflow_d;

  logic              rise;
  logic              byte_done;
  logic [BYTE_W-1:0] push_byte;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [BYTE_W-1:0] fifo_dout;

  assign rise      = cfg_clk_i & ~cfg_clk_prev_q & en_i;
  assign byte_done = rise & (bit_cnt_q == 3'd7);
  assign push_byte = {shreg_q, cfg_dat_i};
  assign fifo_pop  = ~fifo_empty & byte_ready_i;

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    dat_done_d = dat_done_q;
    overflow_d = overflow_q;

    if (rise) begin
      shreg_d   = {shreg_q[BYTE_W-3:0], cfg_dat_i};
      bit_cnt_d = bit_cnt_q + 3'd1;  // wraps 7 -> 0 at byte boundary
    end

    // Counts every completed byte, including dropped ones; never wraps.
    if (byte_done && (byte_cnt_q != '1)) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end

    // Compares the registered count, so done follows it by one cycle.
    if (byte_cnt_q == CNT_W'(TOTAL_BYTES)) begin
      dat_done_d = 1'b1;
    end

    // The FIFO itself refuses the write in this case; just record it.
    if (byte_done && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cfg_clk_prev_q <= 1'b1;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      dat_done_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cfg_clk_prev_q <= cfg_clk_i;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      dat_done_q     <= dat_done_d;
      overflow_q     <= overflow_d;
    end
  end

  cfg_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (byte_done),
    .din_i   (push_byte),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign byte_valid_o = ~fifo_empty;
  // Held at zero while empty so the output is clean out of reset.
  assign byte_o       = fifo_empty ? '0 : fifo_dout;
  assign byte_cnt_o   = byte_cnt_q;
  assign dat_done_o   = dat_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cfg_byte_deser.sv
// -----------------------------------------------------------------------------
// tb_cfg_byte_deser
// Directed bench for cfg_byte_deser (FIFO_DEPTH=16, TOTAL_BYTES=3).
// cfg_clk runs at a period of 4 clk cycles; each bit's rise is the clk edge
// that first samples cfg_clk high.
// -----------------------------------------------------------------------------
module tb_cfg_byte_deser;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        cfg_clk   = 1'b0;
  logic        cfg_dat   = 1'b0;
  logic        en        = 1'b1;
  logic        ready     = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [31:0] byte_cnt;
  logic        dat_done;
  logic        overflow;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic pre_valid    = 1'b0;

  always #5 clk = ~clk;

  cfg_byte_deser #(
    .FIFO_DEPTH  (16),
    .TOTAL_BYTES (3),
    .CNT_W       (32)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cfg_clk_i    (cfg_clk),
    .cfg_dat_i    (cfg_dat),
    .en_i         (en),
    .byte_o       (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ready_i (ready),
    .byte_cnt_o   (byte_cnt),
    .dat_done_o   (dat_done),
    .overflow_o   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising clk edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cfg_clk period; returns just after the edge that registers the rise.
  // pre_valid captures byte_valid during the rise cycle itself.
  task automatic send_bit(input logic b, input logic pop_on_rise);
    step();
    cfg_clk = 1'b0;
    cfg_dat = b;
    step();
    step();
    cfg_clk = 1'b1;
    if (pop_on_rise) ready = 1'b1;
    #3 pre_valid = byte_valid;
    step();
    if (pop_on_rise) ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic pop_last);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], pop_last && (i == 0));
    end
    $display("[TB] sent byte 0x%02h  cnt=%0d valid=%0b head=0x%02h", v, byte_cnt, byte_valid, byte_out);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;

    // ---------------- Test 1: two bytes, ready high ----------------
    step();
    do_reset();
    chk("rst_valid",    {31'd0, byte_valid}, 32'd0);
    chk("rst_byte",     {24'd0, byte_out},   32'd0);
    chk("rst_cnt",      byte_cnt,            32'd0);
    chk("rst_done",     {31'd0, dat_done},   32'd0);
    chk("rst_overflow", {31'd0, overflow},   32'd0);

    ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    chk("t1_a5_prevalid", {31'd0, pre_valid},  32'd0);
    chk("t1_a5_valid",    {31'd0, byte_valid}, 32'd1);
    chk("t1_a5_byte",     {24'd0, byte_out},   32'hA5);
    step();
    chk("t1_a5_popped",   {31'd0, byte_valid}, 32'd0);
    send_byte(8'h3C, 1'b0);
    chk("t1_3c_prevalid", {31'd0, pre_valid},  32'd0);
    chk("t1_3c_valid",    {31'd0, byte_valid}, 32'd1);
    chk("t1_3c_byte",     {24'd0, byte_out},   32'h3C);
    chk("t1_cnt",         byte_cnt,            32'd2);
    chk("t1_overflow",    {31'd0, overflow},   32'd0);
    chk("t1_done",        {31'd0, dat_done},   32'd0);

    // ---------------- Test 2: fill past full, then drain ----------------
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    chk("t2_ovf_at_16", {31'd0, overflow}, 32'd0);
    send_byte(8'h10, 1'b0);
    chk("t2_ovf_at_17", {31'd0, overflow},   32'd1);
    chk("t2_cnt",       byte_cnt,            32'd17);
    chk("t2_valid",     {31'd0, byte_valid}, 32'd1);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_drain%0d", i), {24'd0, byte_out}, i);
      $display("[TB] popped 0x%02h", byte_out);
      step();
    end
    ready = 1'b0;
    chk("t2_empty", {31'd0, byte_valid}, 32'd0);

    // ---------------- Test 3: push on full with simultaneous pop ----------------
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
    send_byte(8'h77, 1'b1);
    chk("t3_overflow", {31'd0, overflow}, 32'd0);
    chk("t3_cnt",      byte_cnt,          32'd17);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? (8'h41 + 8'(i)) : 8'h77;
      chk($sformatf("t3_valid%0d", i), {31'd0, byte_valid}, 32'd1);
      chk($sformatf("t3_drain%0d", i), {24'd0, byte_out},   {24'd0, exp_b});
      $display("[TB] popped 0x%02h", byte_out);
      step();
    end
    ready = 1'b0;
    chk("t3_empty", {31'd0, byte_valid}, 32'd0);

    // ---------------- Test 4: dat_done at TOTAL_BYTES=3 ----------------
    do_reset();
    ready = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("t4_cnt2",  byte_cnt,          32'd2);
    chk("t4_done2", {31'd0, dat_done}, 32'd0);
    send_byte(8'h33, 1'b0);
    chk("t4_cnt3",       byte_cnt,          32'd3);
    chk("t4_done_same",  {31'd0, dat_done}, 32'd0);
    step();
    chk("t4_done_next",  {31'd0, dat_done}, 32'd1);
    send_byte(8'h44, 1'b0);
    chk("t4_done_sticky", {31'd0, dat_done},  32'd1);
    chk("t4_cnt4",        byte_cnt,           32'd4);
    chk("t4_byte4",       {24'd0, byte_out},  32'h44);

    // ---------------- Test 5: reset mid-byte ----------------
    do_reset();
    ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset();
    chk("t5_cnt_rst",   byte_cnt,            32'd0);
    chk("t5_valid_rst", {31'd0, byte_valid}, 32'd0);
    send_byte(8'hFF, 1'b0);
    chk("t5_valid", {31'd0, byte_valid}, 32'd1);
    chk("t5_byte",  {24'd0, byte_out},   32'hFF);
    chk("t5_cnt",   byte_cnt,            32'd1);
    step();
    chk("t5_single", {31'd0, byte_valid}, 32'd0);

    // ---------------- Test 6: cfg_clk high at reset, en gaps ----------------
    cfg_clk = 1'b1;
    cfg_dat = 1'b0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
    step();
    step();
    chk("t6_cnt_rst",   byte_cnt,            32'd0);
    chk("t6_valid_rst", {31'd0, byte_valid}, 32'd0);
    ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    en = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t6_cnt_gap",   byte_cnt,            32'd0);
    chk("t6_valid_gap", {31'd0, byte_valid}, 32'd0);
    en = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    $display("[TB] sent byte 0xc3 with 3 disabled rises  cnt=%0d valid=%0b head=0x%02h",
             byte_cnt, byte_valid, byte_out);
    chk("t6_valid", {31'd0, byte_valid}, 32'd1);
    chk("t6_byte",  {24'd0, byte_out},   32'hC3);
    chk("t6_cnt",   byte_cnt,            32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
